// File: rtl/prbs_bit_checker.sv
// prbs_bit_checker
//   Self-synchronising parallel PRBS checker. It seeds a reference LFSR from
//   the received word and verifies it against lockWords clean words. Once
//   locked, it counts checked bits and bit errors for BER measurement.
//   checked_bits[0] is the earliest bit in time within a word.
// Ports
//   clk           system clock
//   rstb          synchronous reset, active low
//   checked_bits  decided bits from the forward path, one word per cycle
//   en            1 = run the checker; 0 = return to IDLE (counters held)
//   clear         synchronous clear of both counters
//   state         0 IDLE, 1 SEEK, 2 VERIFY, 3 LOCKED
//   locked        state == LOCKED
//   word_err      previous compared word had at least one error
//   err_count     saturating error count (LOCKED words only)
//   bit_count     saturating count of bits checked while LOCKED
module prbs_bit_checker #(
  parameter int unsigned          numChannels   = 32,
  parameter int unsigned          prbsOrder     = 7,
  parameter logic [prbsOrder-1:0] prbsEqn       = 7'h60,
  parameter int unsigned          lockWords     = 8,
  parameter int unsigned          lossWords     = 4,
  parameter int unsigned          errCountWidth = 32,
  parameter int unsigned          bitCountWidth = 48
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     checked_bits [numChannels],
  input  logic                     en,
  input  logic                     clear,
  output logic [1:0]               state,
  output logic                     locked,
  output logic                     word_err,
  output logic [errCountWidth-1:0] err_count,
  output logic [bitCountWidth-1:0] bit_count
);

  localparam int unsigned NERR_W = $clog2(numChannels + 1);
  localparam int unsigned CNT_W  = $clog2(lockWords + 1);
  localparam int unsigned BAD_W  = $clog2(lossWords + 1);
  localparam int unsigned EW1    = errCountWidth + 1;
  localparam int unsigned SEQ_W  = prbsOrder + numChannels;
  localparam logic [bitCountWidth-1:0] BIT_LIMIT =
    {bitCountWidth{1'b1}} - bitCountWidth'(numChannels);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [prbsOrder-1:0]     hist_q, hist_d;     // [0] oldest
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BAD_W-1:0]         bad_q, bad_d;
  logic                     werr_q, werr_d;
  logic [errCountWidth-1:0] err_q;
  logic [bitCountWidth-1:0] bits_q;

  logic [SEQ_W-1:0]         seq;
  logic                     nb;
  logic [NERR_W-1:0]        nerr;
  logic [prbsOrder-1:0]     seed;
  logic                     count_en;
  logic [EW1-1:0]           err_sum;

  // Reference sequence: history in the low bits, then each predicted bit
  // is appended and feeds the following predictions.
  always_comb begin
    seq = '0;
    nb  = 1'b0;
    seq[prbsOrder-1:0] = hist_q;
    for (int unsigned i = 0; i < numChannels; i++) begin
      nb = 1'b0;
      for (int unsigned k = 1; k <= prbsOrder; k++) begin
        nb = nb ^ (prbsEqn[k-1] & seq[prbsOrder+i-k]);
      end
      seq[prbsOrder+i] = nb;
    end
  end

  always_comb begin
    nerr = '0;
    for (int unsigned i = 0; i < numChannels; i++) begin
      nerr = nerr + NERR_W'(checked_bits[i] ^ seq[prbsOrder+i]);
    end
  end

  always_comb begin
    seed = '0;
    for (int unsigned j = 0; j < prbsOrder; j++) begin
      seed[j] = checked_bits[numChannels-prbsOrder+j];
    end
  end

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    werr_d   = 1'b0;
    count_en = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          hist_d  = seed;
          cnt_d   = '0;
          bad_d   = '0;
          state_d = VERIFY;
        end
        VERIFY: begin
          hist_d = seq[numChannels +: prbsOrder];
          werr_d = (nerr != '0);
          if (nerr == '0) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(lockWords)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            state_d = SEEK;
          end
        end
        LOCKED: begin
          hist_d   = seq[numChannels +: prbsOrder];
          werr_d   = (nerr != '0);
          count_en = 1'b1;
          if (nerr > NERR_W'(numChannels / 4)) begin
            bad_d = bad_q + 1'b1;
          end else begin
            bad_d = '0;
          end
          if (bad_d == BAD_W'(lossWords)) begin
            state_d = SEEK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign err_sum = {1'b0, err_q} + EW1'(nerr);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      hist_q  <= '0;
      cnt_q   <= '0;
      bad_q   <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      werr_q  <= werr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb || clear) begin
      err_q  <= '0;
      bits_q <= '0;
    end else if (count_en) begin
      err_q  <= err_sum[errCountWidth] ? '1 : err_sum[errCountWidth-1:0];
      bits_q <= (bits_q > BIT_LIMIT) ? '1 : bits_q + bitCountWidth'(numChannels);
    end
  end

  assign state     = state_q;
  assign locked    = (state_q == LOCKED);
  assign word_err  = werr_q;
  assign err_count = err_q;
  assign bit_count = bits_q;

endmodule
